// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter: serialises MEM-stage and IF-stage
// accesses over one req/ack RAM port and stalls the pipeline until both complete.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  input  logic             mem_rd_i,
  input  logic             mem_wr_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i,
  input  logic             ram_ack_i,
  output logic [31:0]      if_inst_o,
  output logic [31:0]      mem_rdata_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DATA = 2'd1,
    GNT_INST = 2'd2
  } gnt_e;

  gnt_e             gnt_q;
  gnt_e             gnt_cur;
  logic             d_done_q;
  logic             i_done_q;
  logic [31:0]      data_hold_q;
  logic [31:0]      inst_hold_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic dreq;
  logic ireq;
  logic d_pend;
  logic i_pend;
  logic ack_d;
  logic ack_i;
  logic d_ok;
  logic i_ok;
  logic stall;

  // Requests are masked by reset so every combinational output is quiet while rst_i is low.
  always_comb begin
    dreq    = rst_i & (mem_rd_i | mem_wr_i);
    ireq    = rst_i & if_req_i;
    d_pend  = dreq & ~d_done_q;
    i_pend  = ireq & ~i_done_q;

    gnt_cur = gnt_q;
    if (!rst_i) begin
      gnt_cur = GNT_NONE;
    end else if (gnt_q == GNT_NONE) begin
      if (d_pend) begin
        gnt_cur = GNT_DATA;
      end else if (i_pend) begin
        gnt_cur = GNT_INST;
      end
    end

    ack_d = ram_ack_i & (gnt_cur == GNT_DATA);
    ack_i = ram_ack_i & (gnt_cur == GNT_INST);
    d_ok  = ~dreq | d_done_q | ack_d;
    i_ok  = ~ireq | i_done_q | ack_i;
    stall = ~(d_ok & i_ok);
  end

  always_comb begin
    ram_req_o   = (gnt_cur != GNT_NONE);
    ram_we_o    = (gnt_cur == GNT_DATA) & mem_wr_i;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (gnt_cur)
      GNT_DATA: begin
        ram_addr_o  = mem_addr_i;
        ram_wdata_o = mem_wdata_i;
      end
      GNT_INST: ram_addr_o = if_addr_i;
      default: ;
    endcase

    mem_rdata_o = (ack_d & ~mem_wr_i) ? ram_rdata_i : data_hold_q;
    if_inst_o   = ack_i ? ram_rdata_i : inst_hold_q;
    stall_o     = stall;
    stall_cnt_o = stall_cnt_q;
  end

  // Done flags set on ack are overridden by the advance clear when that same edge releases the stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_q       <= GNT_NONE;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      data_hold_q <= '0;
      inst_hold_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ram_ack_i && gnt_cur != GNT_NONE) begin
        gnt_q <= GNT_NONE;
      end else begin
        gnt_q <= gnt_cur;
      end

      if (ack_d) begin
        d_done_q <= 1'b1;
        if (!mem_wr_i) begin
          data_hold_q <= ram_rdata_i;
        end
      end
      if (ack_i) begin
        i_done_q    <= 1'b1;
        inst_hold_q <= ram_rdata_i;
      end

      if (!stall) begin
        d_done_q <= 1'b0;
        i_done_q <= 1'b0;
      end

      if (stall && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  a_req_stable: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    (ram_req_o && !ram_ack_i) |=> (ram_req_o && ram_we_o == $past(ram_we_o)
                                   && ram_addr_o == $past(ram_addr_o))
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table with a transaction scoreboard against a
// wait-state RAM model, plus reset, stray-ack and counter-saturation sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic [31:0] if_inst;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [15:0] stall_cnt;

  int unsigned wait_n   = 0;
  int unsigned wait_cnt = 0;
  int unsigned wc_nxt   = 0;
  logic        force_ack = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0011;
      32'h0000_0004: return 32'h0000_0022;
      32'h0000_0008: return 32'h0000_0033;
      32'h0000_0020: return 32'h8C01_0000;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign ram_ack   = force_ack | (ram_req && wait_cnt == wait_n);
  assign ram_rdata = ram_ack ? mem_lookup(ram_addr) : 32'hBAD0_BAD0;

  mem_port_arbiter #(.CNT_W(16)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .mem_rd_i    (mem_rd),
    .mem_wr_i    (mem_wr),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .ram_ack_i   (ram_ack),
    .if_inst_o   (if_inst),
    .mem_rdata_o (mem_rdata),
    .stall_o     (stall),
    .stall_cnt_o (stall_cnt)
  );

  // Second instance with a narrow counter and a RAM that never acknowledges.
  logic        sat_rst_n = 1'b0;
  logic        sat_if_req = 1'b0;
  logic [31:0] sat_if_addr = 32'h0000_0ABC;
  logic        sat_zero = 1'b0;
  logic [31:0] sat_zero32 = 32'h0;
  logic        sat_req;
  logic        sat_we;
  logic [31:0] sat_addr;
  logic [31:0] sat_wdata;
  logic [31:0] sat_inst;
  logic [31:0] sat_rdata;
  logic        sat_stall;
  logic [3:0]  sat_cnt;

  mem_port_arbiter #(.CNT_W(4)) u_sat (
    .clk_i       (clk),
    .rst_i       (sat_rst_n),
    .if_req_i    (sat_if_req),
    .if_addr_i   (sat_if_addr),
    .mem_rd_i    (sat_zero),
    .mem_wr_i    (sat_zero),
    .mem_addr_i  (sat_zero32),
    .mem_wdata_i (sat_zero32),
    .ram_req_o   (sat_req),
    .ram_we_o    (sat_we),
    .ram_addr_o  (sat_addr),
    .ram_wdata_o (sat_wdata),
    .ram_rdata_i (sat_zero32),
    .ram_ack_i   (sat_zero),
    .if_inst_o   (sat_inst),
    .mem_rdata_o (sat_rdata),
    .stall_o     (sat_stall),
    .stall_cnt_o (sat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned n;
    int unsigned exp_stalls;
    logic [31:0] exp_inst;
    logic [31:0] exp_rdata;
  } vec_t;

  txn_t exp_txn_q[$];
  vec_t pend_q[$];
  vec_t vecs[10];

  // RAM-side monitor: completed transactions are popped from the scoreboard in issue order.
  initial begin
    logic prev_pend;
    txn_t t;
    prev_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wc_nxt    = 0;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) check("req_held_until_ack", 32'(ram_req), 32'd1);
        if (ram_req && ram_ack) begin
          if (exp_txn_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_txn: got addr 0x%08h we %0d, expected no transaction",
                     ram_addr, ram_we);
          end else begin
            t = exp_txn_q.pop_front();
            check("txn_we", 32'(ram_we), 32'(t.we));
            check("txn_addr", ram_addr, t.addr);
            if (t.we) check("txn_wdata", ram_wdata, t.wdata);
          end
        end
        wc_nxt    = (ram_req && !ram_ack) ? wait_cnt + 1 : 0;
        prev_pend = ram_req && !ram_ack;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    wait_cnt <= wc_nxt;
  end

  task automatic drive_idle();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic step(input vec_t v);
    int unsigned k;
    bit          done;
    vec_t        e;
    logic [15:0] cnt0;
    logic [15:0] dcnt;
    @(posedge clk);
    #1;
    check("txn_queue_drained", 32'(exp_txn_q.size()), 32'd0);
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    mem_rd    = v.rd;
    mem_wr    = v.wr;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    wait_n    = v.n;
    if (v.rd || v.wr) exp_txn_q.push_back(txn_t'{v.wr, v.addr, v.wdata});
    if (v.if_req)     exp_txn_q.push_back(txn_t'{1'b0, v.if_addr, 32'h0});
    pend_q.push_back(v);
    cnt0 = stall_cnt;
    k    = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if ((v.rd || v.wr) && k <= v.n) begin
        check("data_issued_first", 32'(ram_req), 32'd1);
        check("data_we", 32'(ram_we), 32'(v.wr));
        check("data_addr", ram_addr, v.addr);
        if (v.wr) check("store_wdata_held", ram_wdata, v.wdata);
      end
      if (!stall) begin
        done = 1;
      end else begin
        k++;
        if (k > 200) begin
          n_vec++;
          n_bad++;
          $display("FAIL stall_timeout: got more than 200 stall cycles, expected %0d", v.exp_stalls);
          done = 1;
        end
      end
    end
    e    = pend_q.pop_front();
    dcnt = stall_cnt - cnt0;
    check("stall_cycles", k, e.exp_stalls);
    check("if_inst", if_inst, e.exp_inst);
    check("mem_rdata", mem_rdata, e.exp_rdata);
    check("stall_cnt_delta", {16'h0, dcnt}, e.exp_stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //        if_req if_addr     rd    wr    addr          wdata         n  stl inst          rdata
    vecs[0] = '{1'b1, 32'h0,     1'b0, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0000_0011, 32'h0};
    vecs[1] = '{1'b1, 32'h4,     1'b0, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0000_0022, 32'h0};
    vecs[2] = '{1'b1, 32'h8,     1'b0, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0000_0033, 32'h0};
    vecs[3] = '{1'b1, 32'h20,    1'b1, 1'b0, 32'h100,      32'h0,        2, 5, 32'h8C01_0000, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'h0,     1'b0, 1'b1, 32'h40,       32'hCAFE_F00D, 2, 2, 32'h8C01_0000, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h0,     1'b1, 1'b1, 32'h44,       32'h1234_5678, 1, 3, 32'h0000_0011, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 32'h4,     1'b1, 1'b0, 32'h8,        32'h0,        0, 1, 32'h0000_0022, 32'h0000_0033};
    vecs[7] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h100,      32'h0,        3, 3, 32'h0000_0022, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0000_0022, 32'hDEAD_BEEF};
    vecs[9] = '{1'b1, 32'h20,    1'b0, 1'b0, 32'h0,        32'h0,        1, 1, 32'h8C01_0000, 32'hDEAD_BEEF};

    // Reset with live requests: outputs must be forced quiet.
    rst_n     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0004;
    mem_rd    = 1'b1;
    mem_wr    = 1'b1;
    mem_addr  = 32'h0000_0100;
    mem_wdata = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    drive_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(vecs[i]);

    // Ack with no grant must change nothing.
    begin
      logic [15:0] c0;
      @(posedge clk);
      #1;
      drive_idle();
      force_ack = 1'b1;
      c0 = stall_cnt;
      repeat (2) begin
        @(negedge clk);
        check("stray_ack_stall", 32'(stall), 32'd0);
        check("stray_ack_req", 32'(ram_req), 32'd0);
        check("stray_ack_if_inst", if_inst, 32'h8C01_0000);
        check("stray_ack_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
      end
      check("stray_ack_cnt", {16'h0, stall_cnt}, {16'h0, c0});
      @(posedge clk);
      #1 force_ack = 1'b0;
    end
    v = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0000_0033, 32'hDEAD_BEEF};
    step(v);

    // Reset while a load waits for ack; the load is abandoned.
    @(posedge clk);
    #1;
    mem_rd   = 1'b1;
    mem_addr = 32'h0000_0100;
    wait_n   = 50;
    repeat (2) @(negedge clk);
    check("midtxn_stall", 32'(stall), 32'd1);
    check("midtxn_req", 32'(ram_req), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midtxn_rst_req", 32'(ram_req), 32'd0);
    check("midtxn_rst_stall", 32'(stall), 32'd0);
    check("midtxn_rst_cnt", {16'h0, stall_cnt}, 32'h0);
    drive_idle();
    wait_n = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    v = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0000_0011, 32'h0};
    step(v);
    v = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 2, 5, 32'h0000_0022, 32'hDEAD_BEEF};
    step(v);
    @(posedge clk);
    #1 drive_idle();

    // Counter saturation on the 4-bit instance.
    sat_if_req = 1'b1;
    @(posedge clk);
    #1 sat_rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sat_cnt_mid", {28'h0, sat_cnt}, 32'd10);
    repeat (20) @(negedge clk);
    check("sat_cnt_max", {28'h0, sat_cnt}, 32'd15);
    check("sat_stall", 32'(sat_stall), 32'd1);
    check("sat_req", 32'(sat_req), 32'd1);
    check("sat_addr", sat_addr, 32'h0000_0ABC);
    check("sat_we", 32'(sat_we), 32'd0);
    check("sat_wdata", sat_wdata, 32'h0);
    check("sat_inst", sat_inst, 32'h0);
    check("sat_rdata", sat_rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
